// File: rtl/sram_ctrl_pkg.sv
// Purpose: shared state encoding and half-word select constants for the SRAM controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    // One state per half-word phase; instruction phases are ordered before data phases.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        I_HI = 3'd1,
        I_LO = 3'd2,
        D_HI = 3'd3,
        D_LO = 3'd4
    } state_e;

    // Value placed on half-word address bit 1 for each half of a 32-bit word.
    localparam logic HALF_HI = 1'b0;  // word bits 31:16
    localparam logic HALF_LO = 1'b1;  // word bits 15:0

    // Phase counter width; large enough for WAIT up to 7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/sram_ctrl_if.sv
// Purpose: CPU-side request bus of the SRAM controller (requests, write data, stall).
// Latency: n/a (signal bundle only).
// Backpressure: the controller holds the CPU through cpu_stall until the word is served.
interface sram_ctrl_if;
    import sram_pkg::*;

    logic        ie;
    logic        de;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic        drw;
    logic [3:0]  dbe;
    logic [31:0] din;
    logic        cpu_stall;

    modport master (
        output ie, de, iaddr, daddr, drw, dbe, din,
        input  cpu_stall
    );

    modport slave (
        input  ie, de, iaddr, daddr, drw, dbe, din,
        output cpu_stall
    );

endinterface

// File: rtl/sram_ctrl_phase.sv
// Purpose: per-phase cycle counter; flags the read capture cycle, the write strobe window and phase end.
// Latency: one phase lasts WAIT+1 cycles; outputs are decoded combinationally from the counter.
// Backpressure: none; the counter only runs while the controller is in a non-idle state.
module sram_phase
    import sram_pkg::*;
#(
    parameter int WAIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    output logic cap_o,
    output logic we_win_o,
    output logic done_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count 0..WAIT inside a phase and wrap to 0 so back-to-back phases restart cleanly.
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last cycle of a phase doubles as read capture point and phase end; the strobe
    // window leaves cycle 0 for address setup and cycle WAIT for hold.
    assign cap_o    = active_i && (cnt_q == LAST);
    assign done_o   = active_i && (cnt_q == LAST);
    assign we_win_o = active_i && (cnt_q != '0) && (cnt_q != LAST);

endmodule

// File: rtl/sram_ctrl.sv
// Purpose: splits 32-bit CPU instruction/data accesses into 16-bit async SRAM half-word phases.
// Latency: 1 + phases*(WAIT+1) cycles of stall; the first stall-low cycle presents valid iout/dout.
// Backpressure: cpu_stall holds the CPU; requests must stay stable until stall drops.
module sram_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int WAIT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    sram_ctrl_if.slave        bus,
    output logic [31:0]       iout,
    output logic [31:0]       dout,
    output logic              sram_clk,
    output logic              sram_adv,
    output logic              sram_cre,
    output logic              sram_ce,
    output logic              sram_oe,
    output logic              sram_we,
    output logic              sram_lb,
    output logic              sram_ub,
    output logic [ADDR_W-1:1] sram_addr,
    inout  wire  [15:0]       sram_data
);

    state_e      state_q, state_d;
    logic        served_q, served_d;
    logic [31:0] iout_q, iout_d;
    logic [31:0] dout_q, dout_d;

    logic        phase_act;
    logic        cap;
    logic        we_win;
    logic        done;
    logic        need_d_hi;
    logic        need_d_lo;
    logic        d_state;
    logic        lo_half;
    logic        wr_phase;
    logic [31:0] addr_src;
    logic [15:0] wr_half;
    logic        unused_addr_bits;

    // A write half with no enabled bytes is skipped; reads always need both halves.
    assign need_d_hi = bus.de && (!bus.drw || (bus.dbe[3:2] != 2'b00));
    assign need_d_lo = bus.de && (!bus.drw || (bus.dbe[1:0] != 2'b00));

    assign phase_act = (state_q != IDLE);
    assign d_state   = (state_q == D_HI) || (state_q == D_LO);
    assign lo_half   = (state_q == I_LO) || (state_q == D_LO);
    assign wr_phase  = d_state && bus.drw;

    sram_phase #(
        .WAIT (WAIT)
    ) u_phase (
        .clk      (clk),
        .rst      (rst),
        .active_i (phase_act),
        .cap_o    (cap),
        .we_win_o (we_win),
        .done_o   (done)
    );

    // Next state: walk I_HI, I_LO, D_HI, D_LO in order, skipping phases that are not needed.
    always_comb begin
        state_d  = state_q;
        served_d = 1'b0;
        case (state_q)
            IDLE: begin
                if ((bus.ie || bus.de) && !served_q) begin
                    if (bus.ie) begin
                        state_d = I_HI;
                    end else if (need_d_hi) begin
                        state_d = D_HI;
                    end else if (need_d_lo) begin
                        state_d = D_LO;
                    end else begin
                        served_d = 1'b1;
                    end
                end
            end
            I_HI: begin
                if (done) begin
                    state_d = I_LO;
                end
            end
            I_LO: begin
                if (done) begin
                    if (need_d_hi) begin
                        state_d = D_HI;
                    end else if (need_d_lo) begin
                        state_d = D_LO;
                    end else begin
                        state_d  = IDLE;
                        served_d = 1'b1;
                    end
                end
            end
            D_HI: begin
                if (done) begin
                    if (need_d_lo) begin
                        state_d = D_LO;
                    end else begin
                        state_d  = IDLE;
                        served_d = 1'b1;
                    end
                end
            end
            D_LO: begin
                if (done) begin
                    state_d  = IDLE;
                    served_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the addressed half-word into the matching output register on the last read cycle.
    always_comb begin
        iout_d = iout_q;
        dout_d = dout_q;
        if (cap && !wr_phase) begin
            case (state_q)
                I_HI:    iout_d[31:16] = sram_data;
                I_LO:    iout_d[15:0]  = sram_data;
                D_HI:    dout_d[31:16] = sram_data;
                D_LO:    dout_d[15:0]  = sram_data;
                default: ;
            endcase
        end
    end

    // State, served flag and output word registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            served_q <= 1'b0;
            iout_q   <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            served_q <= served_d;
            iout_q   <= iout_d;
            dout_q   <= dout_d;
        end
    end

    // Byte lanes: both enabled for reads, taken from the half's byte enables for writes.
    always_comb begin
        sram_ub = 1'b0;
        sram_lb = 1'b0;
        if (wr_phase) begin
            if (lo_half) begin
                sram_ub = !bus.dbe[1];
                sram_lb = !bus.dbe[0];
            end else begin
                sram_ub = !bus.dbe[3];
                sram_lb = !bus.dbe[2];
            end
        end
    end

    assign addr_src  = d_state ? bus.daddr : bus.iaddr;
    assign sram_addr = {addr_src[ADDR_W-1:2], (lo_half ? HALF_LO : HALF_HI)};
    assign wr_half   = lo_half ? bus.din[15:0] : bus.din[31:16];

    // Reset kills the strobe and releases the bus in the same cycle so an aborted write cannot land.
    assign sram_we   = !(wr_phase && we_win && !rst);
    assign sram_data = (wr_phase && !rst) ? wr_half : 16'hzzzz;

    assign sram_clk = 1'b0;
    assign sram_adv = 1'b0;
    assign sram_cre = 1'b0;
    assign sram_ce  = 1'b0;
    assign sram_oe  = 1'b0;

    assign iout = bus.ie ? iout_q : 32'hzzzz_zzzz;
    assign dout = bus.de ? dout_q : 32'hzzzz_zzzz;

    assign bus.cpu_stall = !rst && ((state_q != IDLE) || ((bus.ie || bus.de) && !served_q));

    // Byte-offset and above-range address bits are not forwarded to the SRAM.
    assign unused_addr_bits = ^{bus.iaddr, bus.daddr};

endmodule

// File: tb/tb_sram_ctrl.sv
// Purpose: self-checking bench for sram_ctrl with a byte-lane SRAM model and a vector table.
// Latency: each vector waits for cpu_stall to drop, bounded by a cycle budget.
// Backpressure: the bench behaves as the stalled CPU and holds its request until served.
module tb_sram_ctrl;

    localparam int ADDR_W = 24;
    localparam int WAIT   = 3;

    typedef struct {
        logic        ie;
        logic        de;
        logic        drw;
        logic [3:0]  dbe;
        logic [31:0] iaddr;
        logic [31:0] daddr;
        logic [31:0] din;
        int          exp_stall;
        int          exp_we;
        logic        exp_ub;
        logic        exp_lb;
        logic        chk_i;
        logic [31:0] exp_iout;
        logic        chk_d;
        logic [31:0] exp_dout;
        logic [23:0] exp_a0;
        logic [23:0] exp_a2;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic preload;
    logic tb_drv;

    sram_ctrl_if bus ();

    wire [31:0]       iout;
    wire [31:0]       dout;
    wire              sram_clk, sram_adv, sram_cre, sram_ce, sram_oe;
    wire              sram_we, sram_lb, sram_ub;
    wire [ADDR_W-1:1] sram_addr;
    wire [15:0]       sram_data;

    logic [15:0] mem [0:2047];

    int   checks = 0;
    int   errors = 0;
    vec_t vecs [11];
    vec_t sb [$];

    sram_ctrl #(
        .ADDR_W (ADDR_W),
        .WAIT   (WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .iout      (iout),
        .dout      (dout),
        .sram_clk  (sram_clk),
        .sram_adv  (sram_adv),
        .sram_cre  (sram_cre),
        .sram_ce   (sram_ce),
        .sram_oe   (sram_oe),
        .sram_we   (sram_we),
        .sram_lb   (sram_lb),
        .sram_ub   (sram_ub),
        .sram_addr (sram_addr),
        .sram_data (sram_data)
    );

    always #5 clk = ~clk;

    // The memory drives the bus whenever the held request contains no write.
    assign tb_drv    = !rst && (bus.ie || bus.de) && !(bus.de && bus.drw);
    assign sram_data = tb_drv ? mem[sram_addr[11:1]] : 16'hzzzz;

    // SRAM model: preload once, then store enabled bytes while the write strobe is low.
    always @(posedge clk) begin
        if (preload) begin
            mem[11'h080] <= 16'h1234;
            mem[11'h081] <= 16'h5678;
            mem[11'h100] <= 16'h9ABC;
            mem[11'h101] <= 16'hDEF0;
            mem[11'h180] <= 16'h0F1E;
            mem[11'h181] <= 16'h2D3C;
        end else if (sram_we === 1'b0) begin
            if (sram_ub === 1'b0) mem[sram_addr[11:1]][15:8] <= sram_data[15:8];
            if (sram_lb === 1'b0) mem[sram_addr[11:1]][7:0]  <= sram_data[7:0];
        end
    end

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {16'h0, mem[a[11:1]]};
    endfunction

    function automatic vec_t mk(
        input logic ie, input logic de, input logic drw, input logic [3:0] dbe,
        input logic [31:0] iaddr, input logic [31:0] daddr, input logic [31:0] din,
        input int stall, input int we, input logic ub, input logic lb,
        input logic ci, input logic [31:0] ei, input logic cd, input logic [31:0] ed,
        input logic [23:0] a0, input logic [23:0] a2);
        vec_t v;
        v.ie = ie; v.de = de; v.drw = drw; v.dbe = dbe;
        v.iaddr = iaddr; v.daddr = daddr; v.din = din;
        v.exp_stall = stall; v.exp_we = we; v.exp_ub = ub; v.exp_lb = lb;
        v.chk_i = ci; v.exp_iout = ei; v.chk_d = cd; v.exp_dout = ed;
        v.exp_a0 = a0; v.exp_a2 = a2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          cyc;
        int          we_low;
        int          lane_err;
        logic [23:0] a0;
        logic [23:0] a2;
        logic [31:0] got_i;
        logic [31:0] got_d;
        vec_t        e;
        @(negedge clk);
        bus.ie = v.ie; bus.de = v.de; bus.drw = v.drw; bus.dbe = v.dbe;
        bus.iaddr = v.iaddr; bus.daddr = v.daddr; bus.din = v.din;
        sb.push_back(v);
        cyc = 0; we_low = 0; lane_err = 0; a0 = '0; a2 = '0;
        #1;
        while (bus.cpu_stall === 1'b1 && cyc < 64) begin
            if (cyc == 1) a0 = {sram_addr, 1'b0};
            if (cyc == 9) a2 = {sram_addr, 1'b0};
            if (sram_we === 1'b0) begin
                we_low++;
                if ({sram_ub, sram_lb} !== {v.exp_ub, v.exp_lb}) lane_err++;
            end
            cyc++;
            @(negedge clk);
            #1;
        end
        got_i = iout;
        got_d = dout;
        bus.ie = 1'b0;
        bus.de = 1'b0;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL v%0d scoreboard: got empty queue expected one entry", idx);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d stall_cycles", idx), cyc, e.exp_stall);
            chk($sformatf("v%0d we_low_cycles", idx), we_low, e.exp_we);
            if (e.exp_we > 0) chk($sformatf("v%0d lane_errors", idx), lane_err, 32'd0);
            if (e.chk_i) chk($sformatf("v%0d iout", idx), got_i, e.exp_iout);
            if (e.chk_d) chk($sformatf("v%0d dout", idx), got_d, e.exp_dout);
            if (e.exp_stall > 1) chk($sformatf("v%0d first_phase_addr", idx), {8'h0, a0}, {8'h0, e.exp_a0});
            if (e.exp_stall == 17) chk($sformatf("v%0d third_phase_addr", idx), {8'h0, a2}, {8'h0, e.exp_a2});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //              ie de rw dbe     iaddr        daddr        din           st we ub lb ci iout          cd dout          a0         a2
        vecs[0]  = mk(1, 0, 0, 4'h0, 32'h100, 32'h000, 32'h0,         9,  0, 0, 0, 1, 32'h12345678, 0, 32'h0,        24'h100, 24'h0);
        vecs[1]  = mk(1, 1, 0, 4'h0, 32'h100, 32'h300, 32'h0,         17, 0, 0, 0, 1, 32'h12345678, 1, 32'h0F1E2D3C, 24'h100, 24'h300);
        vecs[2]  = mk(0, 1, 1, 4'h3, 32'h0,   32'h200, 32'hAABBCCDD,  5,  2, 0, 0, 0, 32'h0,        1, 32'h0F1E2D3C, 24'h202, 24'h0);
        vecs[3]  = mk(0, 1, 1, 4'h8, 32'h0,   32'h200, 32'h11223344,  5,  2, 0, 1, 0, 32'h0,        1, 32'h0F1E2D3C, 24'h200, 24'h0);
        vecs[4]  = mk(0, 1, 1, 4'h0, 32'h0,   32'h200, 32'h55555555,  1,  0, 0, 0, 0, 32'h0,        1, 32'h0F1E2D3C, 24'h0,   24'h0);
        vecs[5]  = mk(0, 1, 0, 4'h0, 32'h0,   32'h200, 32'h0,         9,  0, 0, 0, 0, 32'h0,        1, 32'h11BCCCDD, 24'h200, 24'h0);
        vecs[6]  = mk(1, 0, 0, 4'h0, 32'h300, 32'h0,   32'h0,         9,  0, 0, 0, 1, 32'h0F1E2D3C, 0, 32'h0,        24'h300, 24'h0);
        vecs[7]  = mk(0, 1, 1, 4'hF, 32'h0,   32'h300, 32'hCAFEF00D,  9,  4, 0, 0, 0, 32'h0,        1, 32'h11BCCCDD, 24'h300, 24'h0);
        vecs[8]  = mk(1, 1, 0, 4'h0, 32'h200, 32'h300, 32'h0,         17, 0, 0, 0, 1, 32'h11BCCCDD, 1, 32'hCAFEF00D, 24'h200, 24'h300);
        vecs[9]  = mk(0, 1, 1, 4'h4, 32'h0,   32'h200, 32'h00550000,  5,  2, 1, 0, 0, 32'h0,        1, 32'hCAFEF00D, 24'h200, 24'h0);
        vecs[10] = mk(0, 1, 1, 4'h1, 32'h0,   32'h202, 32'h000000EE,  5,  2, 1, 0, 0, 32'h0,        1, 32'hCAFEF00D, 24'h202, 24'h0);

        // Reset with a request already held: stall must stay low and the strobe idle.
        preload = 1'b1;
        rst = 1'b1;
        bus.ie = 1'b1; bus.de = 1'b0; bus.drw = 1'b0; bus.dbe = 4'h0;
        bus.iaddr = 32'h100; bus.daddr = 32'h0; bus.din = 32'h0;
        @(posedge clk);
        #1 preload = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_stall", {31'h0, bus.cpu_stall}, 32'd0);
        chk("reset_we", {31'h0, sram_we}, 32'd1);
        rst = 1'b0;
        bus.ie = 1'b1; bus.de = 1'b1;
        #1;
        chk("reset_iout", iout, 32'h0);
        chk("reset_dout", dout, 32'h0);
        chk("idle_request_stall", {31'h0, bus.cpu_stall}, 32'd1);
        bus.ie = 1'b0; bus.de = 1'b0;
        #1;
        chk("idle_no_request_stall", {31'h0, bus.cpu_stall}, 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        chk("mem_100", memw(32'h100), 32'h1234);
        chk("mem_102", memw(32'h102), 32'h5678);
        chk("mem_200", memw(32'h200), 32'h1155);
        chk("mem_202", memw(32'h202), 32'hCCEE);
        chk("mem_300", memw(32'h300), 32'hCAFE);
        chk("mem_302", memw(32'h302), 32'hF00D);

        // Reset in the middle of a full-word write, during the first strobe cycle of D_HI.
        @(negedge clk);
        bus.ie = 1'b0; bus.de = 1'b1; bus.drw = 1'b1; bus.dbe = 4'hF;
        bus.daddr = 32'h100; bus.din = 32'h12121212;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_we_before_rst", {31'h0, sram_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_we_in_rst", {31'h0, sram_we}, 32'd1);
        chk("abort_stall_in_rst", {31'h0, bus.cpu_stall}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.de = 1'b0;
        #1;
        chk("abort_idle_stall", {31'h0, bus.cpu_stall}, 32'd0);
        chk("abort_we_after", {31'h0, sram_we}, 32'd1);
        bus.ie = 1'b1; bus.de = 1'b1; bus.drw = 1'b0;
        #1;
        chk("abort_iout", iout, 32'h0);
        chk("abort_dout", dout, 32'h0);
        bus.ie = 1'b0; bus.de = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_retry_stall", {31'h0, bus.cpu_stall}, 32'd0);
        chk("abort_mem_100", memw(32'h100), 32'h1234);
        chk("abort_mem_102", memw(32'h102), 32'h5678);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
